// File: rtl/fifo_burst_reader.sv
// Drains an external FIFO in BURST-word bursts (partial burst after TIMEOUT idle cycles) onto a valid/ready stream.
// First beat two cycles after the first pop; a 2-entry skid buffer absorbs m_ready stalls, one beat/cycle when unstalled.

module fifo_burst_reader #(
   parameter int DWIDTH  = 16,
   parameter int AWIDTH  = 4,
   parameter int DEPTH   = 2**AWIDTH,
   parameter int BURST   = 4,
   parameter int TIMEOUT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fifo_empty,
   input  logic [AWIDTH:0]   fifo_num,
   input  logic [DWIDTH-1:0] fifo_out,
   output logic              fifo_pop,
   output logic [DWIDTH-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last
);

   localparam int NW = AWIDTH + 1;
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [NW-1:0] BURST_N  = NW'(BURST);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      POP    = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [TW-1:0]     timer;
   logic [NW-1:0]     len;
   logic [NW-1:0]     pops_left;
   logic [NW-1:0]     beat_cnt;
   logic              in_flight;
   logic [DWIDTH-1:0] buf_dat [2];
   logic              buf_last [2];
   logic              head;
   logic [1:0]        count;

   logic              head_vld;
   logic              accept;
   logic              capture;
   logic              tail;
   logic [1:0]        occ;
   logic              start_full;
   logic              start_part;
   logic              start;
   logic [NW-1:0]     start_len;

   assign head_vld = !reset && (count != 2'd0);
   assign accept   = head_vld && m_ready;
   assign capture  = in_flight;
   assign tail     = head ^ count[0];

   // Occupancy including the word still in flight from the FIFO, net of this cycle's accept.
   assign occ = count + {1'b0, in_flight} - {1'b0, accept};

   assign start_full = (state == IDLE) && (fifo_num >= BURST_N);
   assign start_part = (state == IDLE) && !start_full && (fifo_num != '0) && (timer == TMO_LAST);
   assign start      = start_full || start_part;
   assign start_len  = start_full ? BURST_N : fifo_num;

   always_ff @(posedge clk) begin : state_reg
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin : next_state
      state_nxt = state;
      unique case (state)
         IDLE:    if (start) state_nxt = POP;
         POP:     if (fifo_pop && (pops_left == NW'(1))) state_nxt = FINISH;
         FINISH:  if (accept && m_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin : outputs
      fifo_pop = 1'b0;
      m_valid  = head_vld;
      m_data   = '0;
      m_last   = 1'b0;
      if (!reset && (state == POP) && !fifo_empty && (pops_left != '0) && (occ < 2'd2)) begin
         fifo_pop = 1'b1;
      end
      if (head_vld) begin
         m_data = buf_dat[head];
         m_last = buf_last[head];
      end
   end

   // Timer only runs in IDLE while a partial amount of data is waiting.
   always_ff @(posedge clk) begin : timer_reg
      if (reset) begin
         timer <= '0;
      end else if ((state != IDLE) || start || (fifo_num == '0)) begin
         timer <= '0;
      end else if (fifo_num < BURST_N) begin
         timer <= timer + TW'(1);
      end
   end

   always_ff @(posedge clk) begin : burst_ctrl
      if (reset) begin
         len       <= '0;
         pops_left <= '0;
         beat_cnt  <= '0;
         in_flight <= 1'b0;
      end else begin
         in_flight <= fifo_pop;
         if (start) begin
            len       <= start_len;
            pops_left <= start_len;
            beat_cnt  <= '0;
         end else begin
            if (fifo_pop) pops_left <= pops_left - NW'(1);
            if (capture)  beat_cnt  <= beat_cnt + NW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin : skid_ctrl
      if (reset) begin
         head  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (accept) head <= ~head;
         count <= count + {1'b0, capture} - {1'b0, accept};
      end
   end

   // Data storage needs no reset: m_data is forced to zero whenever the buffer is empty.
   always_ff @(posedge clk) begin : skid_data
      if (capture && !reset) begin
         buf_dat[tail]  <= fifo_out;
         buf_last[tail] <= (beat_cnt == len - NW'(1));
      end
   end

   a_no_pop_on_empty : assert property (@(posedge clk) disable iff (reset) !(fifo_pop && fifo_empty));
   a_buffer_bound    : assert property (@(posedge clk) disable iff (reset) (count <= 2'd2));

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural FIFO (read data valid the cycle after a pop).
// Each task drives one scenario and checks its hand-computed outcome.

module tb_fifo_burst_reader;

   logic        clk;
   logic        reset;
   logic        fifo_empty;
   logic [4:0]  fifo_num;
   logic [15:0] fifo_out;
   logic        fifo_pop;
   logic [15:0] m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;

   fifo_burst_reader dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_num   (fifo_num),
      .fifo_out   (fifo_out),
      .fifo_pop   (fifo_pop),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_last     (m_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests;
   int failed;

   logic [15:0] q[$];
   logic [15:0] src[$];
   logic [15:0] got_dat[$];
   logic        got_last[$];
   int          got_cyc[$];

   int cyc;
   int pop_cnt;
   int pop_empty;
   int stall_err;
   int first_pop;
   int first_num;

   logic        obs_pop;
   logic        obs_valid;
   logic        obs_last;
   logic [15:0] obs_data;
   logic        prev_stall;
   logic [15:0] prev_dat;
   logic        prev_last;

   task automatic fifo_sync();
      fifo_num   = 5'(q.size());
      fifo_empty = (q.size() == 0);
   endtask

   task automatic clear_stats();
      got_dat.delete();
      got_last.delete();
      got_cyc.delete();
      cyc        = 0;
      pop_cnt    = 0;
      pop_empty  = 0;
      stall_err  = 0;
      first_pop  = -1;
      first_num  = -1;
      prev_stall = 1'b0;
   endtask

   // One clock cycle: observe at the falling edge, update the FIFO model just after the rising edge.
   task automatic step();
      logic pend;
      @(negedge clk);
      obs_pop   = fifo_pop;
      obs_valid = m_valid;
      obs_last  = m_last;
      obs_data  = m_data;
      if (fifo_pop) begin
         pop_cnt++;
         if (first_pop < 0) first_pop = cyc;
         if (q.size() == 0) pop_empty++;
      end
      if ((fifo_num != 5'd0) && (first_num < 0)) first_num = cyc;
      if (prev_stall && (!m_valid || (m_data !== prev_dat) || (m_last !== prev_last))) stall_err++;
      prev_stall = m_valid && !m_ready && !reset;
      prev_dat   = m_data;
      prev_last  = m_last;
      if (m_valid && m_ready) begin
         got_dat.push_back(m_data);
         got_last.push_back(m_last);
         got_cyc.push_back(cyc);
      end
      pend = fifo_pop;
      @(posedge clk);
      #1;
      if (pend && (q.size() > 0)) fifo_out = q.pop_front();
      if (src.size() > 0) q.push_back(src.pop_front());
      fifo_sync();
      cyc++;
   endtask

   task automatic start_with(input int n, input int base);
      reset = 1'b1;
      q.delete();
      src.delete();
      for (int i = 0; i < n; i++) q.push_back(16'(base + i));
      fifo_sync();
      step();
      reset = 1'b0;
      clear_stats();
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 5; i++) q.push_back(16'(100 + i));
      fifo_sync();
      clear_stats();
      for (int c = 0; c < 2; c++) begin
         step();
         tests++;
         if ((obs_pop !== 1'b0) || (obs_valid !== 1'b0) || (obs_last !== 1'b0) || (obs_data !== 16'd0)) begin
            $display("FAIL reset_c%0d: pop=%b valid=%b last=%b data=%0d, want all 0", c, obs_pop, obs_valid, obs_last, obs_data);
            failed++;
         end
      end
      tests++;
      if (pop_cnt != 0) begin
         $display("FAIL reset_pops: %0d pops during reset, want 0", pop_cnt);
         failed++;
      end
   endtask

   task automatic test_full_burst();
      m_ready = 1'b1;
      start_with(4, 0);
      for (int i = 0; i < 40 && got_dat.size() < 4; i++) step();
      tests++;
      if (got_dat.size() != 4) begin
         $display("FAIL full_count: %0d beats, want 4", got_dat.size());
         failed++;
      end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if ((got_dat[i] !== 16'(i)) || (got_last[i] !== (i == 3))) begin
            $display("FAIL full_beat%0d: data=%0d last=%b, want data=%0d last=%b", i, got_dat[i], got_last[i], i, (i == 3));
            failed++;
         end
      end
      tests++;
      if (got_cyc[3] - got_cyc[0] != 3) begin
         $display("FAIL full_spacing: beats span %0d cycles, want 3", got_cyc[3] - got_cyc[0]);
         failed++;
      end
      tests++;
      if (got_cyc[0] - first_pop != 2) begin
         $display("FAIL full_latency: first beat %0d cycles after first pop, want 2", got_cyc[0] - first_pop);
         failed++;
      end
      repeat (6) step();
      tests++;
      if ((pop_cnt != 4) || (pop_empty != 0) || (obs_valid !== 1'b0) || (got_dat.size() != 4)) begin
         $display("FAIL full_idle: pops=%0d empty_pops=%0d valid=%b beats=%0d, want 4 0 0 4", pop_cnt, pop_empty, obs_valid, got_dat.size());
         failed++;
      end
   endtask

   task automatic test_backpressure();
      start_with(8, 0);
      for (int i = 0; i < 100 && got_dat.size() < 8; i++) begin
         m_ready = (i % 2 == 0);
         step();
      end
      m_ready = 1'b1;
      tests++;
      if (got_dat.size() != 8) begin
         $display("FAIL bp_count: %0d beats, want 8", got_dat.size());
         failed++;
      end
      for (int i = 0; i < 8; i++) begin
         tests++;
         if ((got_dat[i] !== 16'(i)) || (got_last[i] !== ((i == 3) || (i == 7)))) begin
            $display("FAIL bp_beat%0d: data=%0d last=%b, want data=%0d last=%b", i, got_dat[i], got_last[i], i, ((i == 3) || (i == 7)));
            failed++;
         end
      end
      tests++;
      if ((stall_err != 0) || (pop_cnt != 8) || (pop_empty != 0)) begin
         $display("FAIL bp_flow: stall_changes=%0d pops=%0d empty_pops=%0d, want 0 8 0", stall_err, pop_cnt, pop_empty);
         failed++;
      end
   endtask

   task automatic test_timeout();
      m_ready = 1'b1;
      start_with(0, 0);
      repeat (3) step();
      src.push_back(16'd10);
      src.push_back(16'd11);
      for (int i = 0; i < 40 && got_dat.size() < 2; i++) step();
      tests++;
      if (got_dat.size() != 2) begin
         $display("FAIL tmo_count: %0d beats, want 2", got_dat.size());
         failed++;
      end
      tests++;
      if ((got_dat[0] !== 16'd10) || (got_last[0] !== 1'b0) || (got_dat[1] !== 16'd11) || (got_last[1] !== 1'b1)) begin
         $display("FAIL tmo_beats: %0d/%b %0d/%b, want 10/0 11/1", got_dat[0], got_last[0], got_dat[1], got_last[1]);
         failed++;
      end
      tests++;
      if (first_pop - first_num != 8) begin
         $display("FAIL tmo_delay: first pop %0d cycles after data arrived, want 8", first_pop - first_num);
         failed++;
      end
      repeat (12) step();
      tests++;
      if ((pop_cnt != 2) || (pop_empty != 0)) begin
         $display("FAIL tmo_pops: pops=%0d empty_pops=%0d, want 2 0", pop_cnt, pop_empty);
         failed++;
      end
   endtask

   task automatic test_streaming();
      int lasts;
      m_ready = 1'b1;
      start_with(0, 0);
      for (int i = 0; i < 16; i++) src.push_back(16'(i));
      for (int i = 0; i < 200 && got_dat.size() < 16; i++) step();
      tests++;
      if (got_dat.size() != 16) begin
         $display("FAIL stream_count: %0d beats, want 16", got_dat.size());
         failed++;
      end
      lasts = 0;
      for (int i = 0; i < 16; i++) begin
         if (got_last[i]) lasts++;
         tests++;
         if ((got_dat[i] !== 16'(i)) || (got_last[i] !== (i % 4 == 3))) begin
            $display("FAIL stream_beat%0d: data=%0d last=%b, want data=%0d last=%b", i, got_dat[i], got_last[i], i, (i % 4 == 3));
            failed++;
         end
      end
      tests++;
      if ((lasts != 4) || (pop_cnt != 16) || (pop_empty != 0)) begin
         $display("FAIL stream_flow: lasts=%0d pops=%0d empty_pops=%0d, want 4 16 0", lasts, pop_cnt, pop_empty);
         failed++;
      end
   endtask

   task automatic test_reset_mid_burst();
      m_ready = 1'b1;
      start_with(8, 20);
      for (int i = 0; i < 40 && got_dat.size() < 2; i++) step();
      tests++;
      if ((got_dat.size() != 2) || (got_dat[1] !== 16'd21)) begin
         $display("FAIL mid_pre: %0d beats before reset, want 2 ending in 21", got_dat.size());
         failed++;
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      tests++;
      if ((obs_pop !== 1'b0) || (obs_valid !== 1'b0) || (obs_last !== 1'b0) || (obs_data !== 16'd0)) begin
         $display("FAIL mid_rst: pop=%b valid=%b last=%b data=%0d, want all 0", obs_pop, obs_valid, obs_last, obs_data);
         failed++;
      end
      step();
      tests++;
      if ((obs_pop !== 1'b0) || (obs_valid !== 1'b0) || (obs_last !== 1'b0) || (obs_data !== 16'd0)) begin
         $display("FAIL mid_post: pop=%b valid=%b last=%b data=%0d, want all 0", obs_pop, obs_valid, obs_last, obs_data);
         failed++;
      end
      clear_stats();
      for (int i = 0; i < 40 && got_dat.size() < 4; i++) step();
      tests++;
      if (got_dat.size() != 4) begin
         $display("FAIL mid_count: %0d beats after reset, want 4", got_dat.size());
         failed++;
      end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if ((got_dat[i] !== 16'(24 + i)) || (got_last[i] !== (i == 3))) begin
            $display("FAIL mid_beat%0d: data=%0d last=%b, want data=%0d last=%b", i, got_dat[i], got_last[i], 24 + i, (i == 3));
            failed++;
         end
      end
      tests++;
      if ((pop_cnt != 4) || (pop_empty != 0)) begin
         $display("FAIL mid_pops: pops=%0d empty_pops=%0d, want 4 0", pop_cnt, pop_empty);
         failed++;
      end
   endtask

   initial begin
      tests      = 0;
      failed     = 0;
      reset      = 1'b1;
      m_ready    = 1'b0;
      fifo_out   = 16'd0;
      fifo_num   = 5'd0;
      fifo_empty = 1'b1;
      clear_stats();
      test_reset();
      test_full_burst();
      test_backpressure();
      test_timeout();
      test_streaming();
      test_reset_mid_burst();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, want finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, data width.
REQ-002 SHALL have parameter AWIDTH, default 4, FIFO address width.
REQ-003 SHALL have parameter DEPTH, default 2**AWIDTH, FIFO depth.
REQ-004 SHALL have parameter BURST, default 4, nominal burst length (1..DEPTH).
REQ-005 SHALL have parameter TIMEOUT, default 8, idle cycles before a partial burst (>=1).
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-009 SHALL have port fifo_num  input  AWIDTH+1  FIFO occupancy.
REQ-010 SHALL have port fifo_out  input  DWIDTH  FIFO read data, valid the cycle after a pop.
REQ-011 SHALL have port fifo_pop  output  1  FIFO pop strobe.
REQ-012 SHALL have port m_data  output  DWIDTH  stream data.
REQ-013 SHALL have port m_valid  output  1  stream valid.
REQ-014 SHALL have port m_ready  input  1  stream ready from sink.
REQ-015 SHALL have port m_last  output  1  marks final beat of a burst.

Function
REQ-016 SHALL implement states IDLE, POP, FINISH.
REQ-017 IDLE: SHALL start a burst when fifo_num >= BURST, latching burst length len = BURST, -> POP.
REQ-018 IDLE: timer SHALL clear when fifo_num == 0 or a burst starts, else increment each cycle while 0 < fifo_num < BURST.
REQ-019 IDLE: when timer == TIMEOUT-1 and 0 < fifo_num < BURST, SHALL start a partial burst with len = fifo_num, -> POP.
REQ-020 POP: fifo_pop SHALL assert only when !fifo_empty, pops remaining > 0, and (buffer count + in-flight - accept) < 2, where accept = m_valid && m_ready.
REQ-021 Never SHALL fifo_pop assert while fifo_empty is high, nor more than len times per burst.
REQ-022 POP -> FINISH the cycle the len-th pop issues; FINISH -> IDLE the cycle the beat with m_last is accepted.
REQ-023 SHALL hold a 2-entry output skid buffer; fifo_out captured the cycle after each pop (in-flight flag); data never dropped or duplicated under any m_ready pattern.
REQ-024 m_data/m_valid/m_last SHALL be driven from the buffer head; m_data, m_last SHALL stay stable while m_valid && !m_ready.
REQ-025 m_last SHALL be high exactly on the len-th beat of each burst; beat counter is width sufficient for DEPTH.
REQ-026 Throughput SHALL be one beat per cycle with m_ready held high and FIFO non-empty; first m_valid two cycles after first pop's IDLE->POP decision cycle.
REQ-027 A new burst SHALL NOT start until the previous m_last beat is accepted; a burst in progress SHALL not be re-sized by later fifo_num changes.
REQ-028 Simultaneous buffer write and head accept SHALL update count correctly (count unchanged).

Reset
REQ-029 On reset high at a clock edge: state IDLE, timer 0, buffer empty, in-flight cleared, beat/pop counters 0.
REQ-030 During and after reset: fifo_pop=0, m_valid=0, m_last=0, m_data=0.
REQ-031 Reset mid-burst SHALL abandon the burst; data already popped is discarded; FIFO contents not re-read.

Verification
REQ-032 Reset: assert reset 2 cycles with FIFO holding 5 words -> fifo_pop, m_valid, m_last all 0 throughout.
REQ-033 Full burst: FIFO holds 0,1,2,3, m_ready=1 -> exactly 4 pops, beats 0,1,2,3 on consecutive cycles, m_last only on 3, then IDLE.
REQ-034 Backpressure: 8 words 0..7, m_ready toggling 1,0,1,0... -> two bursts, beats 0..7 in order, no loss/duplication, m_last on 3 and 7, data stable while stalled.
REQ-035 Timeout: FIFO holds 2 words 10,11 with no further pushes -> after 8 idle cycles a burst of 2, m_last on 11, no pop on empty.
REQ-036 Streaming: 16 words 0..15 pushed while reader active, m_ready=1 -> 4 bursts of 4, m_last on 3,7,11,15, fifo_empty never popped.
REQ-037 Reset mid-burst: reset after beat 1 of burst 0..3 -> outputs 0 next cycle; after release next burst begins from the FIFO's next unread word.
